// File: rtl/mfp_serial_tx_pkg.sv
// Shared types and encodings for the MFP serial transmitter.
// Covers the FSM state enum and the UART control field codes with their decode helpers.
package mfp_serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] DB_8 = 2'b00;
    localparam logic [1:0] DB_7 = 2'b01;
    localparam logic [1:0] DB_6 = 2'b10;
    localparam logic [1:0] DB_5 = 2'b11;

    localparam logic [1:0] SB_SYNC = 2'b00;
    localparam logic [1:0] SB_1    = 2'b01;
    localparam logic [1:0] SB_1P5  = 2'b10;
    localparam logic [1:0] SB_2    = 2'b11;

    function automatic logic [3:0] data_bit_count(input logic [1:0] code);
        case (code)
            DB_8:    return 4'd8;
            DB_7:    return 4'd7;
            DB_6:    return 4'd6;
            default: return 4'd5;
        endcase
    endfunction

    function automatic logic [7:0] data_mask(input logic [1:0] code);
        case (code)
            DB_8:    return 8'hFF;
            DB_7:    return 8'h7F;
            DB_6:    return 8'h3F;
            default: return 8'h1F;
        endcase
    endfunction

endpackage

// File: rtl/mfp_serial_tx_if.sv
// Output-FIFO handshake between the MFP FIFO (master) and the line transmitter (slave).
// strobe is a one-clk pop, only raised while data_available=1; data is the head byte and is valid whenever data_available=1.
interface mfp_serial_tx_if;
    logic       data_available;
    logic [7:0] data;
    logic       strobe;

    modport master (output data_available, output data, input strobe);
    modport slave  (input data_available, input data, output strobe);
endinterface

// File: rtl/mfp_bit_timer.sv
// Loadable down-counter gated by clk_en; bit_done pulses on the tick where the count reaches 1.
// A bit loaded with N therefore spans exactly N clk_en ticks.
module mfp_bit_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             bit_done
);

    logic [CNT_W-1:0] count;

    assign bit_done = clk_en && (count == CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (clk_en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mfp_serial_tx.sv
// MFP UART line transmitter: pops bytes from the output FIFO and frames them onto txd.
// Frame format and divisor are captured at launch so mid-frame register writes never corrupt a frame.
module mfp_serial_tx
    import mfp_serial_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    mfp_serial_tx_if.slave   fifo,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       databits,
    input  logic             parity_en,
    input  logic             parity_even,
    input  logic [1:0]       stopbits,
    input  logic             cts,
    output logic             txd,
    output logic             busy,
    output tx_state_e        state_dbg
);

    localparam int CNT_W = DIV_W + 1;

    tx_state_e        state;
    tx_state_e        next_state;
    logic             launch;
    logic             bit_done;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic [CNT_W-1:0] stop_len;
    logic [DIV_W-1:0] div_eff;
    logic [7:0]       masked;

    logic [7:0]       shift_q;
    logic [3:0]       bits_left;
    logic             par_en_q;
    logic             par_bit_q;
    logic [1:0]       stop_q;
    logic [DIV_W-1:0] div_q;

    assign div_eff = (baud_div == '0) ? DIV_W'(1) : baud_div;
    assign masked  = fifo.data & data_mask(databits);
    assign launch  = (state == IDLE) && clk_en && fifo.data_available && cts;

    // Stop length is one bit wider than the divisor so 2*div cannot wrap.
    always_comb begin
        case (stop_q)
            SB_2:    stop_len = {div_q, 1'b0};
            SB_1P5:  stop_len = {1'b0, div_q} + {2'b00, div_q[DIV_W-1:1]};
            default: stop_len = {1'b0, div_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (launch) next_state = START;
            START:  if (bit_done) next_state = DATA;
            DATA:   if (bit_done && (bits_left == 4'd1))
                        next_state = par_en_q ? PARITY : STOP;
            PARITY: if (bit_done) next_state = STOP;
            STOP:   if (bit_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        fifo.strobe = launch;
        busy        = (state != IDLE);
        state_dbg   = state;
        case (state)
            START:   txd = 1'b0;
            DATA:    txd = shift_q[0];
            PARITY:  txd = par_bit_q;
            default: txd = 1'b1;
        endcase
        timer_load = launch || (bit_done && (state != STOP));
        if (launch) begin
            timer_val = {1'b0, div_eff};
        end else if (next_state == STOP) begin
            timer_val = stop_len;
        end else begin
            timer_val = {1'b0, div_q};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q   <= '0;
            bits_left <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop_q    <= '0;
            div_q     <= '0;
        end else if (launch) begin
            shift_q   <= fifo.data;
            bits_left <= data_bit_count(databits);
            par_en_q  <= parity_en;
            par_bit_q <= parity_even ? ^masked : ~^masked;
            stop_q    <= stopbits;
            div_q     <= div_eff;
        end else if ((state == DATA) && bit_done) begin
            shift_q   <= shift_q >> 1;
            bits_left <= bits_left - 4'd1;
        end
    end

    mfp_bit_timer #(.CNT_W(CNT_W)) u_bit_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_en   (clk_en),
        .load     (timer_load),
        .load_val (timer_val),
        .bit_done (bit_done)
    );

endmodule

// File: tb/tb_mfp_serial_tx.sv
// Directed bench for mfp_serial_tx: hand-computed frame waveforms and popped bytes are queued
// by the stimulus and checked by independent strobe and line monitors.
`timescale 1ns/1ps
module tb_mfp_serial_tx;
    import mfp_serial_pkg::*;

    localparam int DIV_W = 16;
    localparam int WW    = 256;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             clk_en = 1'b0;
    logic [DIV_W-1:0] baud_div = 16'd4;
    logic [1:0]       databits = DB_8;
    logic             parity_en = 1'b0;
    logic             parity_even = 1'b0;
    logic [1:0]       stopbits = SB_1;
    logic             cts = 1'b0;
    logic             txd;
    logic             busy;
    tx_state_e        state_dbg;

    mfp_serial_tx_if fifo_if ();

    mfp_serial_tx #(.DIV_W(DIV_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_en      (clk_en),
        .fifo        (fifo_if),
        .baud_div    (baud_div),
        .databits    (databits),
        .parity_en   (parity_en),
        .parity_even (parity_even),
        .stopbits    (stopbits),
        .cts         (cts),
        .txd         (txd),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    // Clock and timing-enable generation
    always #5 clk = ~clk;

    int en_period = 1;
    int en_cnt    = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            en_cnt++;
            if (en_cnt >= en_period) en_cnt = 0;
            clk_en = (en_cnt == 0);
        end
    end

    // Scoreboard state
    logic [WW-1:0] exp_wave_q[$];
    logic [WW-1:0] exp_len_q[$];
    logic [7:0]    exp_pop_q[$];
    logic [7:0]    fifo_q[$];
    int checks     = 0;
    int errors     = 0;
    int strobe_cnt = 0;
    bit pop_req    = 1'b0;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    // FIFO model: head byte changes only after the pop edge
    initial begin
        fifo_if.data_available = 1'b0;
        fifo_if.data           = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (pop_req) begin
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
                pop_req = 1'b0;
            end
            fifo_if.data_available = (fifo_q.size() != 0);
            fifo_if.data           = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        end
    end

    // Strobe monitor
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && fifo_if.strobe) begin
                strobe_cnt++;
                check("strobe_avail", WW'(fifo_if.data_available), WW'(1));
                if (exp_pop_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_unexpected actual=%0h required=none", fifo_if.data);
                end else begin
                    e = exp_pop_q.pop_front();
                    check("strobe_data", WW'(fifo_if.data), WW'(e));
                end
                pop_req = 1'b1;
            end
        end
    end

    // Line monitor: captures txd once per clk while busy, compares when the frame ends
    initial begin
        logic [WW-1:0] cap;
        int            cap_len;
        bit            in_frame;
        cap      = '0;
        cap_len  = 0;
        in_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_frame = 1'b0;
                cap      = '0;
                cap_len  = 0;
            end else if (busy) begin
                in_frame = 1'b1;
                if (cap_len < WW) cap[cap_len] = txd;
                cap_len++;
            end else if (in_frame) begin
                if (exp_wave_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected actual_len=%0d required=none", cap_len);
                end else begin
                    check("frame_len", WW'(cap_len), exp_len_q.pop_front());
                    check("frame_wave", cap, exp_wave_q.pop_front());
                end
                in_frame = 1'b0;
                cap      = '0;
                cap_len  = 0;
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_cfg(input int div, input logic [1:0] db, input logic pe, input logic pev,
                           input logic [1:0] sb, input int per);
        baud_div    = DIV_W'(div);
        databits    = db;
        parity_en   = pe;
        parity_even = pev;
        stopbits    = sb;
        en_period   = per;
    endtask

    // seq[0] is the start bit, seq[nb-1] the last bit before stop, each lasting div clk_en ticks
    task automatic push_frame(input logic [15:0] seq, input int nb, input int div,
                              input int stop_ticks, input int per);
        logic [WW-1:0] w;
        int n;
        w = '0;
        n = 0;
        for (int i = 0; i < nb; i++) begin
            for (int k = 0; k < div * per; k++) begin
                w[n] = seq[i];
                n++;
            end
        end
        for (int k = 0; k < stop_ticks * per; k++) begin
            w[n] = 1'b1;
            n++;
        end
        exp_wave_q.push_back(w);
        exp_len_q.push_back(WW'(n));
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_pop_q.push_back(b);
        fifo_q.push_back(b);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || fifo_q.size() != 0 || exp_wave_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail_now("idle_wait");
    endtask

    task automatic wait_busy(input logic lvl, input int budget);
        int n;
        n = 0;
        while (busy !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== lvl) fail_now("busy_wait");
    endtask

    task automatic wait_strobe(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_if.strobe && n < budget);
        if (!fifo_if.strobe) fail_now("strobe_wait");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int gap;

        repeat (3) @(posedge clk);
        #2;
        check("reset_txd", WW'(txd), WW'(1));
        check("reset_busy", WW'(busy), WW'(0));
        check("reset_strobe", WW'(fifo_if.strobe), WW'(0));
        check("reset_state", WW'(state_dbg), WW'(IDLE));
        reset_n = 1'b1;
        step();

        // 8N1, div 4, 0x55: 0 | 1 0 1 0 1 0 1 0 | stop 4 -> 40 clk busy
        set_cfg(4, DB_8, 1'b0, 1'b0, SB_1, 1);
        cts = 1'b1;
        push_frame(16'h00AA, 9, 4, 4, 1);
        send_byte(8'h55);
        wait_idle(300);

        // 7E1, div 3, 0xC3: 0 | 1 1 0 0 0 0 1 | parity 1; config changed mid-frame is ignored
        set_cfg(3, DB_7, 1'b1, 1'b1, SB_1, 1);
        push_frame(16'h0186, 9, 3, 3, 1);
        send_byte(8'hC3);
        wait_strobe(50);
        step();
        set_cfg(9, DB_8, 1'b0, 1'b0, SB_2, 1);
        cts = 1'b0;
        wait_idle(300);
        cts = 1'b1;
        step();

        // 5O1.5, div 6, clk_en every 2nd clk, 0x1F: 0 | 1 1 1 1 1 | parity 0 | stop 9 ticks
        set_cfg(6, DB_5, 1'b1, 1'b0, SB_1P5, 2);
        push_frame(16'h003E, 7, 6, 9, 2);
        send_byte(8'h1F);
        wait_idle(600);

        // cts low holds the line idle with data waiting
        set_cfg(2, DB_8, 1'b0, 1'b0, SB_1, 1);
        step();
        cts = 1'b0;
        fifo_q.push_back(8'h81);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fifo_if.strobe || !txd || busy) bad++;
        end
        check("cts_hold", WW'(bad), WW'(0));
        push_frame(16'h0102, 9, 2, 2, 1);
        exp_pop_q.push_back(8'h81);
        step();
        cts = 1'b1;
        #1;
        check("cts_release_strobe", WW'(fifo_if.strobe), WW'(1));
        wait_idle(300);

        // reset_n pulsed during the third data bit of 0xF0 (bit value 0)
        set_cfg(4, DB_8, 1'b0, 1'b0, SB_1, 1);
        send_byte(8'hF0);
        wait_strobe(50);
        repeat (14) @(posedge clk);
        #2;
        check("pre_reset_state", WW'(state_dbg), WW'(DATA));
        check("pre_reset_txd", WW'(txd), WW'(0));
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_txd", WW'(txd), WW'(1));
        check("async_reset_busy", WW'(busy), WW'(0));
        check("async_reset_state", WW'(state_dbg), WW'(IDLE));
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (fifo_if.strobe || busy || !txd) bad++;
        end
        check("post_reset_quiet", WW'(bad), WW'(0));

        // 8N2, div 2, back-to-back 0xA5 then 0x3C
        set_cfg(2, DB_8, 1'b0, 1'b0, SB_2, 1);
        step();
        push_frame(16'h014A, 9, 2, 4, 1);
        push_frame(16'h0078, 9, 2, 4, 1);
        send_byte(8'hA5);
        send_byte(8'h3C);
        wait_busy(1'b1, 50);
        wait_busy(1'b0, 100);
        gap = 0;
        while (busy == 1'b0 && gap < 50) begin
            gap++;
            @(negedge clk);
        end
        check("b2b_gap", WW'(gap), WW'(1));
        wait_idle(300);

        // baud_div 0 acts as 1, stop code 00 acts as one stop bit; 0x01
        set_cfg(0, DB_8, 1'b0, 1'b0, SB_SYNC, 1);
        step();
        push_frame(16'h0002, 9, 1, 1, 1);
        send_byte(8'h01);
        wait_idle(100);

        repeat (5) @(negedge clk);
        check("pops_outstanding", WW'(exp_pop_q.size()), WW'(0));
        check("frames_outstanding", WW'(exp_wave_q.size()), WW'(0));
        check("strobe_total", WW'(strobe_cnt), WW'(8));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
